game_controller: RTL and testbench
==================================

// Module: game_controller
// PURPOSE
//  Game-logic sequencer feeding the sprite drawer. Keeps invader formation, ship,
//  bullet and gameplay state in registers and advances them once per video frame.
//  Outputs drive the drawer's invader array/line, ship column, bullet column/row and
//  gameplay inputs directly. Grid: 20 columns (0..19) x 15 visible rows (0..14).
// PARAMETERS
//  INVADER_PERIOD  30  frame ticks per formation step (>=1)
//  BULLET_PERIOD   2   frame ticks per bullet row step (>=1)
//  SHIP_ROW        13  row of the ship; formation reaching it = game over
//  INIT_ARRAY      20'h0FFF0  formation at (re)start, bit n = column n
// PORTS
//  i_clk             in   1   system clock
//  i_reset           in   1   asynchronous, active-low reset (0 = reset)
//  i_frame_tick      in   1   one-cycle pulse per frame; all state updates gated by it
//  i_left            in   1   move-left button, synchronised level
//  i_right           in   1   move-right button, synchronised level
//  i_fire            in   1   fire / restart button, synchronised level
//  o_invaders_array  out  20  live invaders, bit n = column n
//  o_invaders_line   out  4   formation row
//  o_ship_x          out  5   ship column
//  o_bullet_x        out  5   bullet column
//  o_bullet_y        out  4   bullet row; 15 = idle (off-screen)
//  o_gameplay        out  2   00 PLAYING, 01 YOU_WIN, 10 GAME_OVER (11 never driven)
// BEHAVIOUR
//  - Reset (async, i_reset=0) and restart: array=INIT_ARRAY, line=0, dir=RIGHT, ship_x=10,
//    bullet_x=10, bullet_y=15, gameplay=PLAYING, both tick counters=0. All outputs registered.
//  - No state changes on cycles without i_frame_tick; outputs change 1 clk after the tick.
//  - PLAYING, per tick, in order on current register values:
//    1 Hit: bullet active (y!=15), y==line, array[bullet_x]==1 -> clear that bit, bullet_y=15,
//      no bullet step this tick.
//    2 Ship: left only & ship_x>0 -> -1; right only & ship_x<19 -> +1; both/none/edge -> hold.
//    3 Fire: i_fire & bullet idle (after step 1) -> bullet_x=ship_x (pre-move), bullet_y=SHIP_ROW-1,
//      bullet counter=0. Fire while active ignored.
//    4 Bullet: active & not just fired/hit -> counter+1; at BULLET_PERIOD-1 counter=0 and
//      y-1; y==0 on step -> y=15 (idle).
//    5 Formation: counter+1; at INVADER_PERIOD-1 counter=0 and step using post-hit array:
//      RIGHT & bit19 set, or LEFT & bit0 set -> line+1, dir flips, no shift;
//      else RIGHT -> array<<1, LEFT -> array>>1 (no wrap, bits never lost).
//    6 Status: next array==0 -> YOU_WIN; else next line==SHIP_ROW -> GAME_OVER. Win has priority.
//  - YOU_WIN / GAME_OVER: all game registers frozen; tick with i_fire=1 -> restart values,
//    gameplay=PLAYING. Left/right ignored.
//  - Counters sized $clog2(PERIOD+1); line saturates never exceed SHIP_ROW.
// TESTING
//  1 Reset low mid-game, e.g. line=5 -> outputs immediately = 20'h0FFF0,0,10,10,15,00.
//  2 INVADER_PERIOD=1: 4 ticks -> array 0FFF0->1FFE0->3FFC0->7FF80->FFF00; next tick line=1,
//    array FFF00 held; next tick array 7FF80 (moving left).
//  3 Ship at 0 with i_left, 3 ticks -> ship_x stays 0; left+right together -> hold.
//  4 BULLET_PERIOD=1, fire at ship_x=4 with line=0 and bit4 set -> bullet_y 12..0 over ticks,
//    hit tick clears bit4, bullet_y=15; fire again while active -> ignored.
//  5 Clear last invader -> o_gameplay=01 next cycle after tick; tick+fire -> PLAYING, INIT_ARRAY.
//  6 Formation descends to line 13 with invaders left -> o_gameplay=10, outputs frozen.

Source files
------------

// File: rtl/game_controller.sv
// -----------------------------------------------------------------------------
// game_controller
// Frame-rate game sequencer for the invaders sprite drawer. Holds the invader
// formation, ship, bullet and gameplay status in registers. The state advances
// only on cycles where i_frame_tick is high. Every output is a register.
// Grid: 20 columns (0..19) x 15 visible rows (0..14). A bullet row of 15 means
// the bullet is idle (off-screen).
//
// Ports
//   i_clk             system clock
//   i_reset           asynchronous active-low reset
//   i_frame_tick      one-cycle pulse per video frame
//   i_left, i_right   ship movement buttons (synchronised levels)
//   i_fire            fire while playing; restart after a win or a loss
//   o_invaders_array  live invaders, bit n = column n
//   o_invaders_line   formation row
//   o_ship_x          ship column
//   o_bullet_x        bullet column
//   o_bullet_y        bullet row, 15 = idle
//   o_gameplay        00 playing, 01 you win, 10 game over
// -----------------------------------------------------------------------------
module game_controller #(
  parameter int          INVADER_PERIOD = 30,
  parameter int          BULLET_PERIOD  = 2,
  parameter int          SHIP_ROW       = 13,
  parameter logic [19:0] INIT_ARRAY     = 20'h0FFF0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_frame_tick,
  input  logic        i_left,
  input  logic        i_right,
  input  logic        i_fire,
  output logic [19:0] o_invaders_array,
  output logic [3:0]  o_invaders_line,
  output logic [4:0]  o_ship_x,
  output logic [4:0]  o_bullet_x,
  output logic [3:0]  o_bullet_y,
  output logic [1:0]  o_gameplay
);

  localparam int IW = $clog2(INVADER_PERIOD + 1);
  localparam int BW = $clog2(BULLET_PERIOD + 1);

  localparam logic [IW-1:0] INV_LAST = IW'(INVADER_PERIOD - 1);
  localparam logic [BW-1:0] BUL_LAST = BW'(BULLET_PERIOD - 1);
  localparam logic [3:0]    ROW_SHIP = 4'(SHIP_ROW);
  localparam logic [3:0]    ROW_FIRE = 4'(SHIP_ROW - 1);
  localparam logic [3:0]    Y_IDLE   = 4'd15;
  localparam logic [4:0]    X_START  = 5'd10;
  localparam logic [4:0]    X_MAX    = 5'd19;

  typedef enum logic [1:0] {
    PLAYING   = 2'b00,
    YOU_WIN   = 2'b01,
    GAME_OVER = 2'b10
  } play_t;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  logic [19:0]   array_reg, array_next;
  logic [3:0]    line_reg, line_next;
  dir_t          dir_reg, dir_next;
  logic [4:0]    ship_reg, ship_next;
  logic [4:0]    bx_reg, bx_next;
  logic [3:0]    by_reg, by_next;
  logic [IW-1:0] icnt_reg, icnt_next;
  logic [BW-1:0] bcnt_reg, bcnt_next;
  play_t         play_reg, play_next;

  logic          hit;
  logic [19:0]   arr_hit;
  logic          at_edge;

  always_comb begin
    array_next = array_reg;
    line_next  = line_reg;
    dir_next   = dir_reg;
    ship_next  = ship_reg;
    bx_next    = bx_reg;
    by_next    = by_reg;
    icnt_next  = icnt_reg;
    bcnt_next  = bcnt_reg;
    play_next  = play_reg;
    hit        = 1'b0;
    arr_hit    = array_reg;
    at_edge    = 1'b0;

    if (i_frame_tick) begin
      if (play_reg == PLAYING) begin
        // Hit test uses the bullet position from before this frame's step.
        hit = (by_reg != Y_IDLE) && (by_reg == line_reg) && array_reg[bx_reg];
        if (hit) begin
          arr_hit[bx_reg] = 1'b0;
          by_next         = Y_IDLE;
        end

        // Ship: exactly one button, and not against the wall.
        if (i_left && !i_right && (ship_reg != 5'd0)) begin
          ship_next = ship_reg - 5'd1;
        end else if (i_right && !i_left && (ship_reg < X_MAX)) begin
          ship_next = ship_reg + 5'd1;
        end

        // A bullet freed by a hit this frame may be refired at once; the
        // launch column is the ship column before this frame's move.
        if (i_fire && (hit || (by_reg == Y_IDLE))) begin
          bx_next   = ship_reg;
          by_next   = ROW_FIRE;
          bcnt_next = '0;
        end else if (!hit && (by_reg != Y_IDLE)) begin
          if (bcnt_reg == BUL_LAST) begin
            bcnt_next = '0;
            by_next   = (by_reg == 4'd0) ? Y_IDLE : (by_reg - 4'd1);
          end else begin
            bcnt_next = bcnt_reg + BW'(1);
          end
        end

        // Formation step works on the post-hit array so a freshly cleared
        // edge column no longer forces a descent.
        array_next = arr_hit;
        if (icnt_reg == INV_LAST) begin
          icnt_next = '0;
          at_edge   = (dir_reg == DIR_RIGHT) ? arr_hit[19] : arr_hit[0];
          if (at_edge) begin
            if (line_reg < ROW_SHIP) begin
              line_next = line_reg + 4'd1;
            end
            dir_next = (dir_reg == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
          end else if (dir_reg == DIR_RIGHT) begin
            array_next = {arr_hit[18:0], 1'b0};
          end else begin
            array_next = {1'b0, arr_hit[19:1]};
          end
        end else begin
          icnt_next = icnt_reg + IW'(1);
        end

        // An empty formation wins even if it also reached the ship row.
        if (array_next == 20'd0) begin
          play_next = YOU_WIN;
        end else if (line_next == ROW_SHIP) begin
          play_next = GAME_OVER;
        end
      end else if (i_fire) begin
        array_next = INIT_ARRAY;
        line_next  = 4'd0;
        dir_next   = DIR_RIGHT;
        ship_next  = X_START;
        bx_next    = X_START;
        by_next    = Y_IDLE;
        icnt_next  = '0;
        bcnt_next  = '0;
        play_next  = PLAYING;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      array_reg <= INIT_ARRAY;
      line_reg  <= 4'd0;
      dir_reg   <= DIR_RIGHT;
      ship_reg  <= X_START;
      bx_reg    <= X_START;
      by_reg    <= Y_IDLE;
      icnt_reg  <= '0;
      bcnt_reg  <= '0;
      play_reg  <= PLAYING;
    end else begin
      array_reg <= array_next;
      line_reg  <= line_next;
      dir_reg   <= dir_next;
      ship_reg  <= ship_next;
      bx_reg    <= bx_next;
      by_reg    <= by_next;
      icnt_reg  <= icnt_next;
      bcnt_reg  <= bcnt_next;
      play_reg  <= play_next;
    end
  end

  assign o_invaders_array = array_reg;
  assign o_invaders_line  = line_reg;
  assign o_ship_x         = ship_reg;
  assign o_bullet_x       = bx_reg;
  assign o_bullet_y       = by_reg;
  assign o_gameplay       = play_reg;

endmodule

// File: tb/tb_game_controller.sv
// -----------------------------------------------------------------------------
// tb_game_controller
// Two instances: A with fast periods (1/1) and the default formation, B with
// periods 3/2 and a two-invader formation so a win is reachable. A reference
// model produces the expected outputs for each frame; they are queued when the
// stimulus is driven and popped when the registered outputs are sampled.
// -----------------------------------------------------------------------------
module tb_game_controller;

  localparam logic [19:0] INIT_A = 20'h0FFF0;
  localparam logic [19:0] INIT_B = 20'h00300;
  localparam int          SROW   = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic left_a = 1'b0, right_a = 1'b0, fire_a = 1'b0;
  logic left_b = 1'b0, right_b = 1'b0, fire_b = 1'b0;

  logic [19:0] arr_a, arr_b;
  logic [3:0]  line_a, line_b, by_a, by_b;
  logic [4:0]  ship_a, ship_b, bx_a, bx_b;
  logic [1:0]  gp_a, gp_b;

  game_controller #(
    .INVADER_PERIOD(1), .BULLET_PERIOD(1), .SHIP_ROW(SROW), .INIT_ARRAY(INIT_A)
  ) u_a (
    .i_clk(clk), .i_reset(rst), .i_frame_tick(frame_tick),
    .i_left(left_a), .i_right(right_a), .i_fire(fire_a),
    .o_invaders_array(arr_a), .o_invaders_line(line_a), .o_ship_x(ship_a),
    .o_bullet_x(bx_a), .o_bullet_y(by_a), .o_gameplay(gp_a)
  );

  game_controller #(
    .INVADER_PERIOD(3), .BULLET_PERIOD(2), .SHIP_ROW(SROW), .INIT_ARRAY(INIT_B)
  ) u_b (
    .i_clk(clk), .i_reset(rst), .i_frame_tick(frame_tick),
    .i_left(left_b), .i_right(right_b), .i_fire(fire_b),
    .o_invaders_array(arr_b), .o_invaders_line(line_b), .o_ship_x(ship_b),
    .o_bullet_x(bx_b), .o_bullet_y(by_b), .o_gameplay(gp_b)
  );

  typedef struct {
    logic [19:0] arr;
    int line;
    int dir;   // 0 right, 1 left
    int sx;
    int bx;
    int by;
    int gp;
    int ic;
    int bc;
  } mstate_t;

  mstate_t ma, mb;
  mstate_t q_a[$];
  mstate_t q_b[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_cycles = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic mstate_t m_init(logic [19:0] init);
    mstate_t s;
    s.arr = init; s.line = 0; s.dir = 0; s.sx = 10; s.bx = 10;
    s.by = 15; s.gp = 0; s.ic = 0; s.bc = 0;
    return s;
  endfunction

  function automatic mstate_t m_step(mstate_t s, bit l, bit r, bit f,
                                     int ip, int bp, logic [19:0] init);
    mstate_t n;
    bit hit;
    bit edge_set;
    n = s;
    if (s.gp != 0) begin
      if (f) n = m_init(init);
      return n;
    end
    hit = (s.by != 15) && (s.by == s.line) && (((s.arr >> s.bx) & 20'd1) != 0);
    if (hit) begin
      n.arr = n.arr & ~(20'd1 << s.bx);
      n.by  = 15;
    end
    if (l && !r && s.sx > 0)  n.sx = s.sx - 1;
    if (r && !l && s.sx < 19) n.sx = s.sx + 1;
    if (f && n.by == 15) begin
      n.bx = s.sx; n.by = SROW - 1; n.bc = 0;
    end else if (!hit && s.by != 15) begin
      n.bc = s.bc + 1;
      if (n.bc == bp) begin
        n.bc = 0;
        n.by = (s.by == 0) ? 15 : s.by - 1;
      end
    end
    n.ic = s.ic + 1;
    if (n.ic == ip) begin
      n.ic = 0;
      edge_set = (s.dir == 0) ? n.arr[19] : n.arr[0];
      if (edge_set) begin
        if (n.line < SROW) n.line++;
        n.dir = 1 - s.dir;
      end else if (s.dir == 0) begin
        n.arr = n.arr << 1;
      end else begin
        n.arr = n.arr >> 1;
      end
    end
    if (n.arr == 0)          n.gp = 1;
    else if (n.line == SROW) n.gp = 2;
    return n;
  endfunction

  // Would a shot fired now from B's ship column hit anything?
  function automatic bit shot_hits(mstate_t s);
    mstate_t t;
    t = m_step(s, 1'b0, 1'b0, 1'b1, 3, 2, INIT_B);
    for (int i = 0; i < 40; i++) begin
      if (t.by == 15) break;
      t = m_step(t, 1'b0, 1'b0, 1'b0, 3, 2, INIT_B);
    end
    return $countones(t.arr) < $countones(s.arr);
  endfunction

  task automatic cmp_outs(string p, mstate_t e, logic [19:0] arr, logic [3:0] line,
                          logic [4:0] sx, logic [4:0] bx, logic [3:0] by, logic [1:0] gp);
    check_val({p, "_arr"},  32'(arr),  32'(e.arr));
    check_val({p, "_line"}, 32'(line), 32'(e.line));
    check_val({p, "_ship"}, 32'(sx),   32'(e.sx));
    check_val({p, "_bx"},   32'(bx),   32'(e.bx));
    check_val({p, "_by"},   32'(by),   32'(e.by));
    check_val({p, "_gp"},   32'(gp),   32'(e.gp));
  endtask

  task automatic run_cycle(bit tk, bit la, bit ra, bit fa, bit lb, bit rb, bit fb);
    mstate_t ea, eb;
    @(negedge clk);
    frame_tick = tk;
    left_a = la; right_a = ra; fire_a = fa;
    left_b = lb; right_b = rb; fire_b = fb;
    if (tk) begin
      ma = m_step(ma, la, ra, fa, 1, 1, INIT_A);
      mb = m_step(mb, lb, rb, fb, 3, 2, INIT_B);
    end
    q_a.push_back(ma);
    q_b.push_back(mb);
    @(posedge clk);
    #1;
    n_cycles++;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    cmp_outs("a", ea, arr_a, line_a, ship_a, bx_a, by_a, gp_a);
    cmp_outs("b", eb, arr_b, line_b, ship_b, bx_b, by_b, gp_b);
    $display("cyc=%0d tick=%0b A: arr=%05h line=%0d ship=%0d bx=%0d by=%0d gp=%0d | B: arr=%05h line=%0d ship=%0d bx=%0d by=%0d gp=%0d",
             n_cycles, tk, arr_a, line_a, ship_a, bx_a, by_a, gp_a,
             arr_b, line_b, ship_b, bx_b, by_b, gp_b);
  endtask

  task automatic check_reset_outs(string tag);
    check_val({tag, "_a_arr"},  32'(arr_a),  32'(INIT_A));
    check_val({tag, "_a_line"}, 32'(line_a), 32'd0);
    check_val({tag, "_a_ship"}, 32'(ship_a), 32'd10);
    check_val({tag, "_a_bx"},   32'(bx_a),   32'd10);
    check_val({tag, "_a_by"},   32'(by_a),   32'd15);
    check_val({tag, "_a_gp"},   32'(gp_a),   32'd0);
    check_val({tag, "_b_arr"},  32'(arr_b),  32'(INIT_B));
    check_val({tag, "_b_by"},   32'(by_b),   32'd15);
  endtask

  // Reset is asserted between clock edges so the asynchronous path is seen.
  task automatic do_reset(string tag);
    @(negedge clk);
    frame_tick = 1'b0;
    left_a = 1'b0; right_a = 1'b0; fire_a = 1'b0;
    left_b = 1'b0; right_b = 1'b0; fire_b = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_outs(tag);
    @(posedge clk);
    #1 check_reset_outs({tag, "_hold"});
    @(negedge clk);
    rst = 1'b1;
    ma = m_init(INIT_A);
    mb = m_init(INIT_B);
    $display("reset %s done", tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] t2_arr [6];
    int          t2_line [6];
    mstate_t     frz;
    t2_arr  = '{20'h1FFE0, 20'h3FFC0, 20'h7FF80, 20'hFFF00, 20'hFFF00, 20'h7FF80};
    t2_line = '{0, 0, 0, 0, 1, 1};

    do_reset("rst0");

    // Formation marching right, descending at the wall, then heading left.
    // Buttons pressed on non-tick cycles must change nothing.
    for (int k = 0; k < 6; k++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val($sformatf("t2_arr%0d", k),  32'(arr_a),  32'(t2_arr[k]));
      check_val($sformatf("t2_line%0d", k), 32'(line_a), 32'(t2_line[k]));
      run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    end

    // Ship walks to the left wall and sticks; both buttons hold; right wall.
    for (int k = 0; k < 12; k++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t3_left_wall", 32'(ship_a), 32'd0);
    for (int k = 0; k < 3; k++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t3_left_hold", 32'(ship_a), 32'd0);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t3_both_hold", 32'(ship_a), 32'd0);
    for (int k = 0; k < 23; k++) run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t3_right_wall", 32'(ship_a), 32'd19);
    check_val("t3_mid_line", 32'(line_a), 32'd5);

    // Mid-game asynchronous reset.
    do_reset("rst_mid");

    // Fire, refire while active is ignored, bullet climbs into the formation.
    run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("t4_fire_y", 32'(by_a), 32'd12);
    check_val("t4_fire_x", 32'(bx_a), 32'd10);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("t4_refire_y", 32'(by_a), 32'd11);
    check_val("t4_refire_x", 32'(bx_a), 32'd10);
    for (int k = 0; k < 30 && ma.by != 15; k++)
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t4_idle_y", 32'(by_a), 32'd15);
    check_val("t4_one_hit", 32'($countones(arr_a)), 32'd11);

    // Formation reaches the ship row: game over, then everything frozen.
    for (int k = 0; k < 400 && ma.gp == 0; k++)
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t6_gameover", 32'(gp_a), 32'd2);
    check_val("t6_line", 32'(line_a), 32'd13);
    frz = ma;
    for (int k = 0; k < 3; k++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("t6_frozen_ship", 32'(ship_a), 32'(frz.sx));
    check_val("t6_frozen_arr", 32'(arr_a), 32'(frz.arr));
    run_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("t6_restart_gp", 32'(gp_a), 32'd0);
    check_val("t6_restart_arr", 32'(arr_a), 32'(INIT_A));

    // B plays with an aiming autopilot until the formation is cleared.
    do_reset("rst_b");
    for (int k = 0; k < 1500 && mb.gp == 0; k++) begin
      bit f, l, r;
      int tgt;
      f = 1'b0; l = 1'b0; r = 1'b0; tgt = 0;
      if (mb.by == 15 && shot_hits(mb)) begin
        f = 1'b1;
      end else begin
        for (int c = 19; c >= 0; c--) if (mb.arr[c]) tgt = c;
        l = (mb.sx > tgt);
        r = (mb.sx < tgt);
      end
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, l, r, f);
    end
    check_val("t5_win", 32'(gp_b), 32'd1);
    check_val("t5_empty", 32'(arr_b), 32'd0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("t5_notick_hold", 32'(gp_b), 32'd1);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("t5_restart_gp", 32'(gp_b), 32'd0);
    check_val("t5_restart_arr", 32'(arr_b), 32'(INIT_B));
    check_val("t5_restart_line", 32'(line_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
